// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared integer-core constants and typedefs for the register
//                file and its outstanding-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int CNT_W      = 2;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       xlen_t;
   typedef logic [CNT_W-1:0]      cnt_t;

   localparam reg_addr_t ZERO_REG = '0;
   // Highest number of writers a single register may have in flight.
   localparam cnt_t      CNT_MAX  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Per-register 2-bit counters of issued-but-not-written-back
//                writers. Exports busy (cnt != 0), single (cnt == 1) and
//                full (cnt == 3) vectors indexed by register number.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
   import riscv_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                inc_en,
   input  reg_addr_t           inc_addr,
   input  logic                dec_en,
   input  reg_addr_t           dec_addr,
   output logic [NUM_REGS-1:0] busy,
   output logic [NUM_REGS-1:0] single,
   output logic [NUM_REGS-1:0] full
);

   genvar i;
   generate
      for (i = 0; i < NUM_REGS; i++) begin : g_cnt
         if (i == 0) begin : g_zero
            // x0 can never be written, so it never has writers in flight.
            assign busy[i]   = 1'b0;
            assign single[i] = 1'b0;
            assign full[i]   = 1'b0;
         end else begin : g_live
            cnt_t cnt;
            logic inc;
            logic dec;

            // The saturation guard is belt-and-braces: the top stalls the
            // issue when the counter is full, so it is never exercised.
            assign inc = inc_en && (inc_addr == reg_addr_t'(i)) && (cnt != CNT_MAX);
            // A writeback with no tracked writer (e.g. after a flush) must
            // not wrap the counter.
            assign dec = dec_en && (dec_addr == reg_addr_t'(i)) && (cnt != '0);

            // Counter update; an issue and writeback together cancel out.
            always_ff @(posedge clk) begin
               if (!rst_n || flush) begin
                  cnt <= '0;
               end else if (inc && !dec) begin
                  cnt <= cnt + 1'b1;
               end else if (dec && !inc) begin
                  cnt <= cnt - 1'b1;
               end
            end

            assign busy[i]   = (cnt != '0);
            assign single[i] = (cnt == 2'd1);
            assign full[i]   = (cnt == CNT_MAX);
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : 32 x XLEN architectural integer register file, x0 hardwired
//                to zero, two combinational read ports and a RAW-hazard
//                stall driven by the outstanding-write scoreboard.
//                Build option REGFILE_WB_BYPASS_EN: when defined, a same-cycle
//                writeback is forwarded to the read ports and may clear the
//                stall in the writeback cycle itself.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file
   import riscv_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter int NUM_REGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_en,
   input  reg_addr_t       wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  reg_addr_t       rs1_addr,
   input  reg_addr_t       rs2_addr,
   input  logic            rs1_used,
   input  logic            rs2_used,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            issue_valid,
   input  logic            issue_rd_en,
   input  reg_addr_t       issue_rd,
   input  logic            flush,
   output logic            stall
);

`ifdef REGFILE_WB_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   logic [XLEN-1:0]                regs [NUM_REGS];
   logic [riscv_pkg::NUM_REGS-1:0] busy;
   logic [riscv_pkg::NUM_REGS-1:0] single;
   logic [riscv_pkg::NUM_REGS-1:0] full;
   logic                           rs1_bypass;
   logic                           rs2_bypass;
   logic                           rs1_covered;
   logic                           rs2_covered;
   logic                           rs1_hazard;
   logic                           rs2_hazard;
   logic                           rd_wants_issue;
   logic                           rd_full;
   logic                           inc_en;

   // Register array: reset clears everything, writes to x0 are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs[r] <= '0;
         end
      end else if (wb_en && (wb_addr != ZERO_REG)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Forwarding matches are qualified by rst_n so a writeback presented
   // during reset never leaks onto the read ports.
   assign rs1_bypass = BYPASS_EN && rst_n && wb_en && (wb_addr == rs1_addr)
                       && (rs1_addr != ZERO_REG);
   assign rs2_bypass = BYPASS_EN && rst_n && wb_en && (wb_addr == rs2_addr)
                       && (rs2_addr != ZERO_REG);

   // Read port 1: zero for x0 or in reset, else forwarded or stored data.
   always_comb begin
      rs1_data = '0;
      if (!rst_n || (rs1_addr == ZERO_REG)) begin
         rs1_data = '0;
      end else if (rs1_bypass) begin
         rs1_data = wb_data;
      end else begin
         rs1_data = regs[rs1_addr];
      end
   end

   // Read port 2: same selection as port 1.
   always_comb begin
      rs2_data = '0;
      if (!rst_n || (rs2_addr == ZERO_REG)) begin
         rs2_data = '0;
      end else if (rs2_bypass) begin
         rs2_data = wb_data;
      end else begin
         rs2_data = regs[rs2_addr];
      end
   end

   // A source is covered when the writeback being forwarded this cycle is
   // its only remaining producer.
   assign rs1_covered = rs1_bypass && single[rs1_addr];
   assign rs2_covered = rs2_bypass && single[rs2_addr];

   assign rs1_hazard = rs1_used && (rs1_addr != ZERO_REG) && busy[rs1_addr] && !rs1_covered;
   assign rs2_hazard = rs2_used && (rs2_addr != ZERO_REG) && busy[rs2_addr] && !rs2_covered;

   assign rd_wants_issue = issue_valid && issue_rd_en && (issue_rd != ZERO_REG);
   assign rd_full        = rd_wants_issue && full[issue_rd];

   // The counters are meaningless before the first reset edge, so the stall
   // is forced low for as long as reset is held.
   assign stall  = rst_n && (rs1_hazard || rs2_hazard || rd_full);
   assign inc_en = rd_wants_issue && !stall;

   reg_scoreboard u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .inc_en   (inc_en),
      .inc_addr (issue_rd),
      .dec_en   (wb_en),
      .dec_addr (wb_addr),
      .busy     (busy),
      .single   (single),
      .full     (full)
   );

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Self-checking bench for register_file. A behavioural model
//                (plain arrays of values and writer counts) predicts read data
//                and stall; each scenario task compares the DUT inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

`ifdef REGFILE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [63:0] wb_data;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        rs1_used;
   logic        rs2_used;
   logic [63:0] rs1_data;
   logic [63:0] rs2_data;
   logic        issue_valid;
   logic        issue_rd_en;
   logic [4:0]  issue_rd;
   logic        flush;
   logic        stall;

   register_file #(.XLEN(64), .NUM_REGS(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_used    (rs1_used),
      .rs2_used    (rs2_used),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .issue_valid (issue_valid),
      .issue_rd_en (issue_rd_en),
      .issue_rd    (issue_rd),
      .flush       (flush),
      .stall       (stall)
   );

   always #5 clk = ~clk;

   // Reference state: architectural values and number of writers in flight.
   logic [63:0] m_regs [32];
   int          m_cnt  [32];
   logic [63:0] exp_rs1;
   logic [63:0] exp_rs2;
   logic        exp_stall;
   int          total = 0;
   int          bad   = 0;

   function automatic logic [63:0] ref_read(input logic [4:0] a);
      if (!rst_n || a == 5'd0) return 64'd0;
      if (BYP && wb_en && wb_addr == a) return wb_data;
      return m_regs[a];
   endfunction

   function automatic logic ref_hazard(input logic used, input logic [4:0] a);
      if (!used || a == 5'd0 || m_cnt[a] == 0) return 1'b0;
      // Forwarding the last pending producer satisfies the consumer now.
      if (BYP && wb_en && wb_addr == a && m_cnt[a] == 1) return 1'b0;
      return 1'b1;
   endfunction

   task automatic predict();
      exp_rs1   = ref_read(rs1_addr);
      exp_rs2   = ref_read(rs2_addr);
      exp_stall = rst_n && (ref_hazard(rs1_used, rs1_addr) || ref_hazard(rs2_used, rs2_addr) ||
                  (issue_valid && issue_rd_en && issue_rd != 5'd0 && m_cnt[issue_rd] == 3));
   endtask

   // Advance one clock and apply the same edge to the model.
   task automatic step();
      bit issue_counts;
      bit wb_retires;
      predict();
      @(posedge clk);
      if (!rst_n) begin
         for (int r = 0; r < 32; r++) begin
            m_regs[r] = 64'd0;
            m_cnt[r]  = 0;
         end
      end else begin
         issue_counts = issue_valid && issue_rd_en && issue_rd != 5'd0 && !exp_stall;
         wb_retires   = wb_en && wb_addr != 5'd0 && m_cnt[wb_addr] > 0;
         if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
         if (flush) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
         end else begin
            if (issue_counts) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
            if (wb_retires)   m_cnt[wb_addr]  = m_cnt[wb_addr] - 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      rst_n = 1'b1; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 64'd0;
      rs1_addr = 5'd0; rs2_addr = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
      issue_valid = 1'b0; issue_rd_en = 1'b0; issue_rd = 5'd0; flush = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0; wb_en = 1'b1; wb_addr = 5'd4; wb_data = {$urandom, $urandom};
      rs1_addr = 5'd4; rs1_used = 1'b1;
      step();
      #1; predict(); total++;
      if (rs1_data !== 64'd0 || stall !== 1'b0) begin
         bad++; $display("FAIL reset_hold: rs1=%h stall=%b want 0/0", rs1_data, stall);
      end
      step();
      idle();
      for (int a = 1; a < 32; a++) begin
         rs1_addr = 5'(a); rs2_addr = 5'(32 - a); rs1_used = 1'b1; rs2_used = 1'b1;
         #1; predict(); total++;
         if (rs1_data !== 64'd0 || rs2_data !== 64'd0 || stall !== 1'b0) begin
            bad++; $display("FAIL reset_read x%0d: rs1=%h rs2=%h stall=%b want zeros", a, rs1_data, rs2_data, stall);
         end
         step();
      end
      idle(); wb_en = 1'b1; wb_addr = 5'd0; wb_data = 64'hDEAD;
      step();
      idle(); rs1_addr = 5'd0; rs2_addr = 5'd0;
      #1; predict(); total++;
      if (rs1_data !== 64'd0 || rs2_data !== 64'd0) begin
         bad++; $display("FAIL x0_write: rs1=%h rs2=%h want 0", rs1_data, rs2_data);
      end
      step();
   endtask

   task automatic test_write_read();
      idle(); wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'h1234_5678_9ABC_DEF0;
      rs1_addr = 5'd5;
      #1; predict(); total++;
      if (rs1_data !== exp_rs1) begin
         bad++; $display("FAIL wr_same_cycle: rs1=%h want %h", rs1_data, exp_rs1);
      end
      step();
      idle(); rs1_addr = 5'd5; rs2_addr = 5'd5;
      #1; total++;
      if (rs1_data !== 64'h1234_5678_9ABC_DEF0 || rs2_data !== 64'h1234_5678_9ABC_DEF0) begin
         bad++; $display("FAIL wr_next_cycle: rs1=%h rs2=%h want 123456789abcdef0", rs1_data, rs2_data);
      end
      step();
   endtask

   task automatic test_raw_stall();
      idle(); issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd7;
      #1; predict(); total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL raw_issue: stall=%b want 0", stall);
      end
      step();
      // Consumer of x7 held in decode.
      idle(); issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd8;
      rs1_addr = 5'd7; rs1_used = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1; predict(); total++;
         if (stall !== 1'b1 || stall !== exp_stall) begin
            bad++; $display("FAIL raw_wait c%0d: stall=%b want 1", c, stall);
         end
         step();
      end
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 64'h0777_0000_CAFE_F00D;
      #1; predict(); total++;
      if (stall !== !BYP || stall !== exp_stall) begin
         bad++; $display("FAIL raw_wb_cycle: stall=%b want %b", stall, !BYP);
      end
      step();
      wb_en = 1'b0;
      #1; predict(); total++;
      if (stall !== 1'b0 || rs1_data !== 64'h0777_0000_CAFE_F00D) begin
         bad++; $display("FAIL raw_release: stall=%b rs1=%h want 0/0777_0000_cafef00d", stall, rs1_data);
      end
      step();
   endtask

   task automatic test_full();
      idle(); issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd3;
      for (int c = 0; c < 5; c++) begin
         #1; predict(); total++;
         if (stall !== (c >= 3) || stall !== exp_stall) begin
            bad++; $display("FAIL full_issue%0d: stall=%b want %b", c, stall, c >= 3);
         end
         step();
      end
      // Full: issue blocked, writeback retires one (3 -> 2).
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'h33;
      #1; predict(); total++;
      if (stall !== 1'b1) begin
         bad++; $display("FAIL full_wb: stall=%b want 1", stall);
      end
      step();
      // Issue and writeback together: count holds at 2.
      #1; predict(); total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL full_cancel: stall=%b want 0", stall);
      end
      step();
      idle(); rs1_addr = 5'd3; rs1_used = 1'b1; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'h34;
      #1; predict(); total++;
      if (stall !== 1'b1) begin
         bad++; $display("FAIL full_drain2: stall=%b want 1", stall);
      end
      step();
      wb_data = 64'h35;
      #1; predict(); total++;
      if (stall !== !BYP || stall !== exp_stall) begin
         bad++; $display("FAIL full_drain1: stall=%b want %b", stall, !BYP);
      end
      step();
      wb_en = 1'b0;
      #1; predict(); total++;
      if (stall !== 1'b0 || rs1_data !== 64'h35) begin
         bad++; $display("FAIL full_empty: stall=%b rs1=%h want 0/35", stall, rs1_data);
      end
      step();
   endtask

   task automatic test_flush();
      idle(); issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd9;
      step();
      idle(); flush = 1'b1; issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd10;
      wb_en = 1'b1; wb_addr = 5'd11; wb_data = 64'hB11B;
      step();
      idle(); rs1_addr = 5'd9; rs2_addr = 5'd10; rs1_used = 1'b1; rs2_used = 1'b1;
      #1; predict(); total++;
      if (stall !== 1'b0 || rs2_data !== exp_rs2) begin
         bad++; $display("FAIL flush_clear: stall=%b want 0", stall);
      end
      step();
      idle(); wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'h9999_0000_9999_0000;
      step();
      // Underflow would wrap the count to 3 and block this issue.
      idle(); rs1_addr = 5'd9; rs2_addr = 5'd11; issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd9;
      #1; predict(); total++;
      if (stall !== 1'b0 || rs1_data !== 64'h9999_0000_9999_0000 || rs2_data !== 64'hB11B) begin
         bad++; $display("FAIL flush_wb: stall=%b rs1=%h rs2=%h want 0/9999000099990000/b11b", stall, rs1_data, rs2_data);
      end
      step();
      idle(); rs1_addr = 5'd9; rs1_used = 1'b1;
      #1; predict(); total++;
      if (stall !== 1'b1) begin
         bad++; $display("FAIL flush_recount: stall=%b want 1", stall);
      end
      step();
   endtask

   task automatic test_reset_mid();
      idle(); issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd12;
      step();
      idle(); rst_n = 1'b0; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 64'h4444;
      issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd12;
      step();
      idle(); rs1_addr = 5'd4; rs2_addr = 5'd12; rs1_used = 1'b1; rs2_used = 1'b1;
      #1; predict(); total++;
      if (rs1_data !== 64'd0 || stall !== 1'b0) begin
         bad++; $display("FAIL reset_mid: rs1=%h stall=%b want 0/0", rs1_data, stall);
      end
      step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst_n       = ($urandom_range(0, 79) != 0);
         flush       = ($urandom_range(0, 39) == 0);
         wb_en       = $urandom_range(0, 1);
         wb_addr     = 5'($urandom_range(0, 7));
         wb_data     = {$urandom, $urandom};
         rs1_addr    = 5'($urandom_range(0, 7));
         rs2_addr    = 5'($urandom_range(0, 7));
         rs1_used    = $urandom_range(0, 1);
         rs2_used    = $urandom_range(0, 1);
         issue_valid = $urandom_range(0, 1);
         issue_rd_en = ($urandom_range(0, 3) != 0);
         issue_rd    = 5'($urandom_range(0, 7));
         #1; predict();
         total++;
         if (rs1_data !== exp_rs1) begin
            bad++; $display("FAIL rand_rs1 c%0d: got %h want %h", c, rs1_data, exp_rs1);
         end
         total++;
         if (rs2_data !== exp_rs2) begin
            bad++; $display("FAIL rand_rs2 c%0d: got %h want %h", c, rs2_data, exp_rs2);
         end
         total++;
         if (stall !== exp_stall) begin
            bad++; $display("FAIL rand_stall c%0d: got %b want %b", c, stall, exp_stall);
         end
         step();
      end
   endtask

   initial begin
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = 64'd0;
         m_cnt[r]  = 0;
      end
      idle();
      test_reset();
      test_write_read();
      test_raw_stall();
      test_full();
      test_flush();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/register_file.md
# register_file

Architectural integer register file for the pipelined core: the receiving end of the writeback stage's `write_back_data`/`write_back_addr`/`reg_write_back` bus. It has these parts:
- 32 × 64-bit registers with x0 hardwired to zero.
- Two combinational read ports for decode.
- A per-register outstanding-write scoreboard that raises a decode stall while a source operand is still in flight.

It sits between decode (reads, issue) and writeback (writes).

## Interface
Parameters:
- XLEN, 64, register width
- NUM_REGS, 32, register count; address width fixed at 5

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- wb_en  in  1  write enable from writeback (`reg_write_back`)
- wb_addr  in  5  destination register from writeback
- wb_data  in  XLEN  write data from writeback
- rs1_addr, rs2_addr  in  5  decode source addresses
- rs1_used, rs2_used  in  1  source actually consumed by the decoded instruction
- rs1_data, rs2_data  out  XLEN  read data
- issue_valid  in  1  decoded instruction leaves decode this cycle
- issue_rd_en  in  1  issued instruction writes a register
- issue_rd  in  5  its destination
- flush  in  1  pipeline flush; discard all outstanding-write tracking
- stall  out  1  decode must hold

## Operation
- **Write**
  - At the rising edge, if `rst_n` is 1, `wb_en` is 1 and `wb_addr` ≠ 0, then `regs[wb_addr]` ← `wb_data`.
  - Writes to x0 are dropped.
- **Read**
  - Reads are combinational.
  - Address 0 always returns 0.
  - Otherwise the port returns `regs[addr]`, subject to the bypass (see Configuration).
- **Scoreboard**
  - Each register r has a 2-bit counter `cnt[r]` holding the number of issued, not yet written-back writers of r.
  - Increment condition: `issue_valid && issue_rd_en && issue_rd != 0 && !stall` increments `cnt[issue_rd]`.
  - Decrement condition: `wb_en && wb_addr != 0 && cnt[wb_addr] != 0` decrements `cnt[wb_addr]`.
  - Both conditions on the same register in one cycle: the count is unchanged.
  - A writeback to a register with count 0 (for example after a flush) updates the register and leaves the count at 0, with no underflow.
  - `cnt[0]` is constant 0.
- **Hazard**
  - `rsN_hazard` = `rsN_used && rsN_addr != 0 && cnt[rsN_addr] != 0 && !rsN_covered`.
  - `stall` = `rs1_hazard | rs2_hazard | (issue_valid && issue_rd_en && issue_rd != 0 && cnt[issue_rd] == 3)`.
  - When `stall` is 1, the scoreboard does not count the issue in that cycle.
- **Flush**
  - A synchronous flush clears every counter to 0.
  - A simultaneous writeback still updates the register array.
  - A simultaneous issue is ignored.
- **Reset**
  - `rst_n` = 0 at an edge clears all registers to 0 and all counters to 0.
  - `wb_en` is ignored during that cycle, including a reset asserted mid-operation.
  - While `rst_n` is low: `rs1_data`/`rs2_data` = 0 (the array is 0 after the first reset edge) and `stall` = 0.

## Timing
- Write latency: 1 cycle. Data is visible from the array on the cycle after the `wb_en` edge.
- Read latency: 0 cycles, combinational from the address inputs and current state.
- Counter updates take effect at the rising edge. `stall` is combinational from the current counts and current inputs.
- A held instruction keeps `issue_valid` asserted. `stall` deasserts in the cycle its last producer is covered (bypass build) or one cycle after that producer's writeback (no-bypass build).

## Configuration
Macro `REGFILE_WB_BYPASS_EN`.

- **Defined**
  - Write-through bypass is enabled.
  - When `wb_en && wb_addr == rsN_addr && rsN_addr != 0`, `rsN_data` = `wb_data` in the same cycle.
  - `rsN_covered` = that bypass match with `cnt[rsN_addr] == 1`.
- **Undefined**
  - Reads return stored array contents only.
  - `rsN_covered` = 0, so decode waits one extra cycle after the writeback.

## Structure
- **Shared package `riscv_pkg`:** `XLEN`, `REG_ADDR_W` = 5, `NUM_REGS`, `ZERO_REG` = 0, and the `reg_addr_t` / `xlen_t` typedefs.
- **Sub-module `reg_scoreboard`:**
  - Contains the counter array, the increment/decrement/flush logic and the `cnt == 3` full check.
  - Exports the per-register busy vector and count lookups.
- **Top level:** the register array, read muxes, bypass and the stall combine.

## Test plan
- Reset then read x1..x31: all return 0 and `stall` = 0. Write x0 = 0xDEAD, read x0: returns 0.
- `wb_en` = 1, `wb_addr` = 5, `wb_data` = 0x1234_5678_9ABC_DEF0:
  - The next cycle, `rs1_addr` = 5 returns that value.
  - Same-cycle read returns it only with `REGFILE_WB_BYPASS_EN` defined.
- Issue rd = 7, then decode `rs1_addr` = 7 with `rs1_used` = 1:
  - `stall` = 1 until x7 is written back.
  - Deasserts in the writeback cycle (bypass build) or one cycle later (no-bypass build).
- Issue rd = 3 three times:
  - A fourth issue of rd = 3 raises `stall` and `cnt[3]` stays 3.
  - Simultaneous issue rd = 3 and writeback x3 leaves `cnt[3]` unchanged.
- Issue rd = 9, assert `flush`:
  - `cnt[9]` = 0 and a read of x9 does not stall.
  - A later writeback of x9 updates data without underflow.
- Assert `rst_n` = 0 while `wb_en` = 1, `wb_addr` = 4: x4 stays 0 and all counters clear.
